mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single core memory port between the fetch stage (read-only instruction requests) and the load/store unit (read/write data requests). Arbitrates requests, holds the chosen requester until the memory grants, and records the owner of every in-flight transaction so that in-order responses are routed back to the correct requester. Sits between the pipeline stages and the external/bus-side memory interface.

## Interface
- OUTSTANDING, 2: max in-flight (granted, not yet responded) transactions; ≥1
- MAX_DATA_RUN, 4: consecutive data grants allowed while instr is waiting before instr is forced to win
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- data_req_i  in  1  LSU request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU request accepted this cycle
- data_rvalid_o  out  1  LSU response valid (reads and writes)
- data_rdata_o  out  32  LSU read data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write enable (0 for instr)
- mem_be_o  out  4  byte enables (4'hF for instr)
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data (0 for instr)
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid, in request order
- mem_rdata_i  in  32  memory read data
- err_o  out  1  sticky: response received with nothing outstanding

## Operation
- Requesters follow req/gnt: req and payload held stable until gnt; gnt only when req.
- Owner selection (combinational, when not locked): data wins over instr, unless run counter == MAX_DATA_RUN and instr_req_i, then instr wins.
- Lock: if mem_req_o=1 and mem_gnt_i=0, owner registered and held next cycles until gnt; losing requester sees gnt=0 throughout.
- mem_* payload muxed from owner; mem_req_o = owner's req & (count < OUTSTANDING).
- X_gnt_o = mem_gnt_i & mem_req_o & (owner==X); never both gnt in one cycle.
- Run counter (3+ bits, saturating at MAX_DATA_RUN): +1 on data grant while instr_req_i=1; cleared on instr grant or on any cycle instr_req_i=0.
- Owner FIFO: OUTSTANDING entries × 1 bit (0=instr,1=data), plus count 0..OUTSTANDING. Push owner on grant; pop on mem_rvalid_i.
- Response routing: head owner selects X_rvalid_o = mem_rvalid_i; both rdata outputs driven with mem_rdata_i.
- Grant and rvalid same cycle: push and pop both performed, count unchanged; response routed from pre-push head (push into empty FIFO with same-cycle rvalid cannot occur—see err).
- Full (count==OUTSTANDING): mem_req_o=0, no grants, even if rvalid arrives that cycle (no bypass).
- mem_rvalid_i with count==0: no pop, both rvalid outputs 0, err_o set, cleared only by reset.

## Timing
- Reset values: FIFO empty, count 0, run counter 0, lock clear, err_o 0; with mem inputs low all gnt/rvalid outputs 0.
- Arbitration, grant and response routing are zero-latency (combinational paths req→mem_req_o, mem_gnt_i→X_gnt_o, mem_rvalid_i→X_rvalid_o).
- FIFO/count/lock/run-counter update on rising clk_i; new grant visible in count next cycle.
- Reset mid-transaction: in-flight ownership discarded; later mem_rvalid_i with count 0 sets err_o.

## Test plan
- Instr only, addr 0x100, mem_gnt_i=1, rvalid next cycle data 0xDEADBEEF -> instr_gnt_o=1, mem_be_o=4'hF, mem_we_o=0; instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
- Both request continuously, mem_gnt_i=1 every cycle, rvalid 1 cycle later -> grants D,D,D,D,I,D,D,D,D,I…; responses routed to matching owner.
- Data req with mem_gnt_i=0 for 3 cycles, instr_req_i raised in cycle 2 -> owner stays data, instr_gnt_o=0 until data granted in cycle 4.
- OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 while count=2; one rvalid -> next cycle mem_req_o=1 again.
- Grant and rvalid same cycle at count=1 -> count stays 1, response to old head owner.
- mem_rvalid_i=1 at count=0 -> no rvalid outputs, err_o=1 until rst_ni low.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single core memory port between the fetch stage (read-only)
//   and the load/store unit (read/write). Data normally wins arbitration.
//   Once data has been granted MAX_DATA_RUN times in a row while fetch was
//   waiting, fetch is forced to win. A requester that is presented but not
//   granted is locked in until the memory grants it. The owner of every
//   in-flight transaction is queued so that in-order responses are routed
//   back to the requester that issued them.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   instr_*              fetch req/gnt/rvalid channel (32-bit address/rdata)
//   data_*               LSU req/gnt/rvalid channel (we, be, addr, wdata, rdata)
//   mem_*                memory-side request/grant/response channel
//   err_o                sticky: a response arrived with nothing outstanding
module mem_port_arbiter #(
  parameter int OUTSTANDING  = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int RUN_W = ($clog2(MAX_DATA_RUN + 1) < 3) ? 3 : $clog2(MAX_DATA_RUN + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);

  // Owner FIFO entries: 0 = instr, 1 = data
  logic [OUTSTANDING-1:0] owner_fifo_q, owner_fifo_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic                   lock_q, lock_d;
  logic                   lock_owner_q, lock_owner_d;
  logic                   err_q, err_d;

  logic owner_data;
  logic owner_req;
  logic full;
  logic empty;
  logic grant;
  logic push;
  logic pop;
  logic head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Arbitration and memory-side request
  always_comb begin
    if (lock_q) begin
      owner_data = lock_owner_q;
    end else begin
      owner_data = data_req_i && !(instr_req_i && (run_q == RUN_MAX));
    end
    owner_req = owner_data ? data_req_i : instr_req_i;
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    // No issue while the owner FIFO is full, even if a response frees a slot
    // this cycle: the response path never feeds back into the request path.
    mem_req_o   = owner_req && !full;
    mem_we_o    = owner_data ? data_we_i    : 1'b0;
    mem_be_o    = owner_data ? data_be_i    : 4'hF;
    mem_addr_o  = owner_data ? data_addr_i  : instr_addr_i;
    mem_wdata_o = owner_data ? data_wdata_i : 32'h0;
    grant       = mem_req_o && mem_gnt_i;
    instr_gnt_o = grant && !owner_data;
    data_gnt_o  = grant && owner_data;
  end

  // Response routing from the oldest outstanding owner
  always_comb begin
    head_data      = owner_fifo_q[rd_ptr_q];
    pop            = mem_rvalid_i && !empty;
    push           = grant;
    instr_rvalid_o = pop && !head_data;
    data_rvalid_o  = pop && head_data;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    err_o          = err_q;
  end

  // Owner FIFO storage, one bit per slot
  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_owner_slot
    assign owner_fifo_d[gi] = (push && (wr_ptr_q == PTR_W'(gi))) ? owner_data
                                                                 : owner_fifo_q[gi];
  end

  // Next-state logic for pointers, count, lock, run counter and error flag
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // The lock captures whoever was presented but stalled; it stays set
    // (even while full blocks the request) until that requester is granted.
    lock_d       = lock_q ? !grant : (mem_req_o && !mem_gnt_i);
    lock_owner_d = lock_q ? lock_owner_q : owner_data;

    run_d = run_q;
    if (!instr_req_i || instr_gnt_o) begin
      run_d = '0;
    end else if (data_gnt_o && (run_q != RUN_MAX)) begin
      run_d = run_q + RUN_W'(1);
    end

    err_d = err_q || (mem_rvalid_i && empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_fifo_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      run_q        <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      owner_fifo_q <= owner_fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      run_q        <= run_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int OUTSTANDING  = 2;
  localparam int MAX_DATA_RUN = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.OUTSTANDING(OUTSTANDING), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: queue of in-flight owners (1 = data), data run length,
  // locked requester (-1 none, 0 instr, 1 data) and sticky error.
  bit own_q[$];
  int run_m;
  int lock_m;
  bit err_m;
  // Stimulus knobs (percentages) and requester bookkeeping
  int p_ireq, p_dreq, p_gnt, p_rv;
  bit instr_done, data_done;
  bit last_gnt_valid, last_gnt_data;

  task automatic model_reset();
    own_q.delete();
    run_m  = 0;
    lock_m = -1;
    err_m  = 0;
  endtask

  task automatic drive();
    if (instr_done) begin instr_req_i = 1'b0; instr_done = 0; end
    if (data_done)  begin data_req_i  = 1'b0; data_done  = 0; end
    if (!instr_req_i && ($urandom_range(99) < p_ireq)) begin
      instr_req_i  = 1'b1;
      instr_addr_i = $urandom;
    end
    if (!data_req_i && ($urandom_range(99) < p_dreq)) begin
      data_req_i   = 1'b1;
      data_we_i    = 1'($urandom_range(1));
      data_be_i    = 4'($urandom_range(15));
      data_addr_i  = $urandom;
      data_wdata_i = $urandom;
    end
    mem_gnt_i    = ($urandom_range(99) < p_gnt);
    mem_rvalid_i = (own_q.size() > 0) && ($urandom_range(99) < p_rv);
    mem_rdata_i  = $urandom;
  endtask

  // Called just after a negedge with inputs applied: checks outputs against
  // the model, then advances the model at the following rising edge.
  task automatic eval_cycle();
    bit full, own_d, oreq, ereq, egnt, has_head, head, erv;
    #1;
    full     = (own_q.size() >= OUTSTANDING);
    if (lock_m >= 0) own_d = (lock_m == 1);
    else             own_d = data_req_i && !(run_m == MAX_DATA_RUN && instr_req_i);
    oreq     = own_d ? data_req_i : instr_req_i;
    ereq     = oreq && !full;
    egnt     = ereq && mem_gnt_i;
    has_head = (own_q.size() > 0);
    head     = has_head ? own_q[0] : 1'b0;
    erv      = mem_rvalid_i && has_head;
    check_eq("ctrl", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o},
             {ereq, egnt && !own_d, egnt && own_d, erv && !head, erv && head, err_m});
    if (ereq) begin
      check_eq("payload", {mem_addr_o, mem_wdata_o},
               own_d ? {data_addr_i, data_wdata_i} : {instr_addr_i, 32'h0});
      check_eq("we_be", {mem_we_o, mem_be_o}, own_d ? {data_we_i, data_be_i} : {1'b0, 4'hF});
    end
    if (erv) check_eq("rdata", {instr_rdata_o, data_rdata_o}, {mem_rdata_i, mem_rdata_i});
    last_gnt_valid = egnt;
    last_gnt_data  = own_d;
    @(posedge clk_i);
    if (mem_rvalid_i && !has_head) err_m = 1;
    if (erv) void'(own_q.pop_front());
    if (egnt) own_q.push_back(own_d);
    if (egnt) lock_m = -1;
    else if (ereq) lock_m = own_d ? 1 : 0;
    if (!instr_req_i || (egnt && !own_d)) run_m = 0;
    else if (egnt && own_d && run_m < MAX_DATA_RUN) run_m++;
    if (egnt) begin
      if (own_d) data_done = 1;
      else       instr_done = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    drive();
    eval_cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    instr_done = 0; data_done = 0;
    model_reset();
    #1;
    check_eq("reset", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o}, 6'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [9:0] seq;
  int         ngnt;

  initial begin
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
    data_addr_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    instr_done = 0; data_done = 0;
    apply_reset();

    // Instruction fetch alone, response one cycle later
    @(negedge clk_i);
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    eval_cycle();
    @(negedge clk_i);
    instr_req_i = 0; instr_done = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #1 check_eq("instr_resp", {instr_rvalid_o, data_rvalid_o, instr_rdata_o}, {2'b10, 32'hDEADBEEF});
    eval_cycle();

    // Data stalled three cycles; instr raised in the second must not steal it
    @(negedge clk_i);
    mem_rvalid_i = 0; data_req_i = 1; data_we_i = 1; data_be_i = 4'h3;
    data_addr_i = 32'h200; data_wdata_i = 32'h1234; mem_gnt_i = 0;
    eval_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      instr_req_i = 1; instr_addr_i = 32'h300;
      mem_gnt_i = (c == 2);
      #1 check_eq("lock_hold", {instr_gnt_o, data_gnt_o}, {1'b0, c == 2});
      eval_cycle();
    end

    // Fill the owner FIFO with no responses: request must be blocked
    p_ireq = 100; p_dreq = 50; p_gnt = 100; p_rv = 0;
    repeat (4) cycle();
    @(negedge clk_i);
    #1 check_eq("full_block", mem_req_o, 1'b0);
    p_rv = 100;
    cycle();
    p_rv = 0;
    repeat (2) cycle();

    // Both requesting continuously: DDDDI DDDDI pattern
    apply_reset();
    p_ireq = 100; p_dreq = 100; p_gnt = 100; p_rv = 100;
    seq = '0; ngnt = 0;
    for (int c = 0; c < 30 && ngnt < 10; c++) begin
      cycle();
      if (last_gnt_valid) begin seq = {seq[8:0], last_gnt_data}; ngnt++; end
    end
    check_eq("run_pattern", {22'(ngnt), seq}, {22'd10, 10'b1111011110});

    // Reset with a transaction in flight, then a stray response sets err
    apply_reset();
    @(negedge clk_i);
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    eval_cycle();
    @(negedge clk_i);
    mem_rvalid_i = 0;
    #1 check_eq("err_set", err_o, 1'b1);
    eval_cycle();
    apply_reset();
    @(negedge clk_i);
    #1 check_eq("err_clr", err_o, 1'b0);

    // Randomized traffic under varying pressure
    for (int k = 0; k < 6; k++) begin
      p_ireq = $urandom_range(20, 100); p_dreq = $urandom_range(20, 100);
      p_gnt  = $urandom_range(20, 100); p_rv   = $urandom_range(10, 90);
      repeat (400) cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
